interrupt_scheduler: RTL and testbench

//  Arbitrates NUM_SRC interrupt request sources (frame-ready tick, jump key, future inputs) onto the single

---
 rtl/interrupt_scheduler_if.sv | 45 ++++
 rtl/interrupt_scheduler.sv | 141 ++++++++++++++
 tb/tb_interrupt_scheduler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_scheduler_if.sv
// ---------------------------------------------------------------------------
// interrupt_scheduler_if
//  Bundles the request, handshake and status signals between the interrupt
//  scheduler and its surroundings (request sources plus processor).
//  master : the side that raises requests and models the processor
//  slave  : the scheduler itself
// Signals
//  src_req               per-source request, one request per high cycle
//  src_instr             per-source instruction, source i at [32i+31:32i]
//  proc_ready            processor can take an interrupt this cycle
//  isr_done              one-cycle pulse on ISR return
//  missed_clr            clears the sticky missed[] bits
//  interrupt_instruction injected instruction, zero when not issuing
//  issue_id              source index of the last grant
//  pending               latched, unserviced requests
//  missed                sticky coalesced-request flags
//  busy                  high while issuing or waiting for ISR completion
//  timeout_err           sticky ISR-completion timeout flag
// ---------------------------------------------------------------------------
interface interrupt_scheduler_if #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 3
);
    logic [NUM_SRC-1:0]    src_req;
    logic [NUM_SRC*32-1:0] src_instr;
    logic                  proc_ready;
    logic                  isr_done;
    logic                  missed_clr;
    logic [31:0]           interrupt_instruction;
    logic [ID_W-1:0]       issue_id;
    logic [NUM_SRC-1:0]    pending;
    logic [NUM_SRC-1:0]    missed;
    logic                  busy;
    logic                  timeout_err;

    modport master (
        output src_req, src_instr, proc_ready, isr_done, missed_clr,
        input  interrupt_instruction, issue_id, pending, missed, busy, timeout_err
    );

    modport slave (
        input  src_req, src_instr, proc_ready, isr_done, missed_clr,
        output interrupt_instruction, issue_id, pending, missed, busy, timeout_err
    );
endinterface

// File: rtl/interrupt_scheduler.sv
// ---------------------------------------------------------------------------
// interrupt_scheduler
//  Latches interrupt requests from NUM_SRC sources, arbitrates them (fixed
//  priority or round-robin) and injects exactly one instruction per grant
//  into the processor, then waits for ISR completion (or a timeout) before
//  granting again.
// Ports
//  proc_clk  processor clock, all state changes on posedge
//  reset     asynchronous, active-high
//  bus       interrupt_scheduler_if.slave (requests, handshake, status)
// ---------------------------------------------------------------------------
module interrupt_scheduler #(
    parameter int NUM_SRC = 4,
    parameter int RR_EN   = 0,
    parameter int TIMEOUT = 4096,
    parameter int ID_W    = 3
) (
    input  logic                  proc_clk,
    input  logic                  reset,
    interrupt_scheduler_if.slave  bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t             state_reg, state_next;
    logic [NUM_SRC-1:0] pending_reg, missed_reg;
    logic [ID_W-1:0]    issue_id_reg, rr_ptr_reg;
    logic [31:0]        instr_reg;
    logic [CNT_W-1:0]   wait_cnt_reg;
    logic               timeout_err_reg;

    logic [NUM_SRC-1:0]   grant_onehot, miss_hit;
    logic [2*NUM_SRC-1:0] pend_rot;
    logic [ID_W-1:0]      rr_start, grant_off, grant_idx;
    logic [ID_W:0]        grant_sum;
    logic                 grant_found, grant_valid, timeout_hit;
    logic [31:0]          sel_instr;
    logic [31:0]          src_word [NUM_SRC];

    // Arbitration: rotate the pending vector so the search start sits at
    // bit 0, take the lowest set bit, then add the start back with wrap.
    // Fixed priority is the same search with the start pinned to 0.
    assign rr_start = (RR_EN != 0) ? rr_ptr_reg : '0;

    always_comb begin
        pend_rot    = {pending_reg, pending_reg} >> rr_start;
        grant_found = 1'b0;
        grant_off   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!grant_found && pend_rot[i]) begin
                grant_found = 1'b1;
                grant_off   = ID_W'(i);
            end
        end
        grant_sum = {1'b0, rr_start} + {1'b0, grant_off};
        if (grant_sum >= (ID_W+1)'(NUM_SRC)) begin
            grant_sum = grant_sum - (ID_W+1)'(NUM_SRC);
        end
        grant_idx = grant_sum[ID_W-1:0];
    end

    assign grant_valid = (state_reg == IDLE) && bus.proc_ready && grant_found;

    // A miss is a request landing on an already-pending source that is not
    // being granted at the same edge.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_word[gi]     = bus.src_instr[32*gi +: 32];
            assign grant_onehot[gi] = grant_valid && (grant_idx == ID_W'(gi));
            assign miss_hit[gi]     = bus.src_req[gi] && pending_reg[gi] && !grant_onehot[gi];
        end
    endgenerate

    always_comb begin
        sel_instr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_onehot[i]) begin
                sel_instr = sel_instr | src_word[i];
            end
        end
    end

    // isr_done wins over the timeout in the same cycle.
    assign timeout_hit = (TIMEOUT != 0) && (state_reg == WAIT_DONE) &&
                         !bus.isr_done && (wait_cnt_reg == CNT_LAST);

    always_ff @(posedge proc_clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (grant_valid) state_next = ISSUE;
            ISSUE:     state_next = WAIT_DONE;
            WAIT_DONE: if (bus.isr_done || timeout_hit) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge proc_clk or posedge reset) begin
        if (reset) begin
            pending_reg     <= '0;
            missed_reg      <= '0;
            issue_id_reg    <= '0;
            rr_ptr_reg      <= '0;
            instr_reg       <= '0;
            wait_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            // A request and a grant of the same source leave it pending.
            pending_reg <= (pending_reg & ~grant_onehot) | bus.src_req;
            missed_reg  <= (bus.missed_clr ? '0 : missed_reg) | miss_hit;
            // Loaded only on the grant edge, so it is nonzero only in ISSUE.
            instr_reg   <= grant_valid ? sel_instr : 32'd0;
            if (grant_valid) begin
                issue_id_reg <= grant_idx;
                rr_ptr_reg   <= (grant_idx == ID_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
            end
            // Counter is held at zero outside WAIT_DONE, so it is clear on entry.
            wait_cnt_reg <= (state_reg == WAIT_DONE) ? wait_cnt_reg + 1'b1 : '0;
            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign bus.interrupt_instruction = instr_reg;
    assign bus.issue_id              = issue_id_reg;
    assign bus.pending               = pending_reg;
    assign bus.missed                = missed_reg;
    assign bus.busy                  = (state_reg != IDLE);
    assign bus.timeout_err           = timeout_err_reg;

endmodule

// File: tb/tb_interrupt_scheduler.sv
// ---------------------------------------------------------------------------
// tb_interrupt_scheduler
//  Drives identical random traffic into a fixed-priority and a round-robin
//  scheduler (4 sources, timeout 8) and compares every output each cycle
//  against a behavioural model of the request/grant/ISR protocol.
// ---------------------------------------------------------------------------
module tb_interrupt_scheduler;
    localparam int N   = 4;
    localparam int TMO = 8;
    localparam int IDW = 3;
    localparam int CYCLES = 2500;

    logic proc_clk = 1'b0;
    logic reset    = 1'b1;
    always #5 proc_clk = ~proc_clk;

    interrupt_scheduler_if #(.NUM_SRC(N), .ID_W(IDW)) bus_fix ();
    interrupt_scheduler_if #(.NUM_SRC(N), .ID_W(IDW)) bus_rr ();

    interrupt_scheduler #(.NUM_SRC(N), .RR_EN(0), .TIMEOUT(TMO), .ID_W(IDW)) dut_fix (
        .proc_clk (proc_clk),
        .reset    (reset),
        .bus      (bus_fix)
    );

    interrupt_scheduler #(.NUM_SRC(N), .RR_EN(1), .TIMEOUT(TMO), .ID_W(IDW)) dut_rr (
        .proc_clk (proc_clk),
        .reset    (reset),
        .bus      (bus_rr)
    );

    int checks   = 0;
    int failures = 0;

    // Model state, index 0 = fixed priority, 1 = round-robin.
    // phase: 0 idle, 1 issuing, 2 waiting for ISR completion
    int          m_phase [2];
    bit [N-1:0]  m_pend  [2];
    bit [N-1:0]  m_miss  [2];
    int          m_wait  [2];
    int          m_rr    [2];
    logic [31:0] m_instr [2];
    int          m_id    [2];
    bit          m_terr  [2];
    int          m_issues[2];

    // Stimulus for the coming edge
    bit [N-1:0]  cur_req;
    logic [31:0] cur_word [N];
    bit          cur_ready, cur_done, cur_clr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_phase[k] = 0;
        m_pend[k]  = '0;
        m_miss[k]  = '0;
        m_wait[k]  = 0;
        m_rr[k]    = 0;
        m_instr[k] = '0;
        m_id[k]    = 0;
        m_terr[k]  = 1'b0;
    endtask

    // Advance one model by one clock edge using the cur_* stimulus.
    task automatic model_step(input int k);
        int         g;
        int         start;
        int         c;
        bit [N-1:0] nxt_pend;
        bit [N-1:0] nxt_miss;
        g = -1;
        if (m_phase[k] == 0 && m_pend[k] != 0 && cur_ready) begin
            start = (k == 1) ? m_rr[k] : 0;
            for (int off = 0; off < N; off++) begin
                c = (start + off) % N;
                if (g < 0 && m_pend[k][c]) g = c;
            end
        end
        nxt_miss = cur_clr ? '0 : m_miss[k];
        for (int i = 0; i < N; i++) begin
            if (cur_req[i] && m_pend[k][i] && g != i) nxt_miss[i] = 1'b1;
            nxt_pend[i] = cur_req[i] | (m_pend[k][i] & (g != i));
        end
        m_instr[k] = '0;
        case (m_phase[k])
            0: if (g >= 0) begin
                m_phase[k] = 1;
                m_instr[k] = cur_word[g];
                m_id[k]    = g;
                m_rr[k]    = (g + 1) % N;
                m_issues[k]++;
                $display("[%0t] %s grant src=%0d instr=%h", $time, (k == 1) ? "rr " : "fix", g, cur_word[g]);
            end
            1: begin
                m_phase[k] = 2;
                m_wait[k]  = 0;
            end
            default: begin
                if (cur_done) begin
                    m_phase[k] = 0;
                end else if (m_wait[k] == TMO - 1) begin
                    m_phase[k] = 0;
                    m_terr[k]  = 1'b1;
                    $display("[%0t] %s ISR timeout", $time, (k == 1) ? "rr " : "fix");
                end else begin
                    m_wait[k]++;
                end
            end
        endcase
        m_pend[k] = nxt_pend;
        m_miss[k] = nxt_miss;
    endtask

    task automatic compare_inst(input int k, input string nm,
                                input logic [31:0] instr, input logic [IDW-1:0] id,
                                input logic [N-1:0] pend, input logic [N-1:0] miss,
                                input logic busy, input logic terr);
        check({nm, ".instr"},   instr,       m_instr[k]);
        check({nm, ".issue_id"}, 32'(id),    32'(m_id[k]));
        check({nm, ".pending"}, 32'(pend),   32'(m_pend[k]));
        check({nm, ".missed"},  32'(miss),   32'(m_miss[k]));
        check({nm, ".busy"},    32'(busy),   32'(m_phase[k] != 0));
        check({nm, ".timeout"}, 32'(terr),   32'(m_terr[k]));
    endtask

    task automatic compare_all();
        compare_inst(0, "fix", bus_fix.interrupt_instruction, bus_fix.issue_id, bus_fix.pending,
                     bus_fix.missed, bus_fix.busy, bus_fix.timeout_err);
        compare_inst(1, "rr", bus_rr.interrupt_instruction, bus_rr.issue_id, bus_rr.pending,
                     bus_rr.missed, bus_rr.busy, bus_rr.timeout_err);
    endtask

    task automatic drive_inputs();
        logic [N*32-1:0] flat;
        for (int i = 0; i < N; i++) flat[32*i +: 32] = cur_word[i];
        bus_fix.src_req    = cur_req;
        bus_rr.src_req     = cur_req;
        bus_fix.src_instr  = flat;
        bus_rr.src_instr   = flat;
        bus_fix.proc_ready = cur_ready;
        bus_rr.proc_ready  = cur_ready;
        bus_fix.isr_done   = cur_done;
        bus_rr.isr_done    = cur_done;
        bus_fix.missed_clr = cur_clr;
        bus_rr.missed_clr  = cur_clr;
    endtask

    initial begin
        cur_req   = '0;
        cur_ready = 1'b0;
        cur_done  = 1'b0;
        cur_clr   = 1'b0;
        for (int i = 0; i < N; i++) cur_word[i] = '0;
        drive_inputs();
        for (int k = 0; k < 2; k++) begin
            model_reset(k);
            m_issues[k] = 0;
        end

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge proc_clk);
            compare_all();

            for (int i = 0; i < N; i++) begin
                cur_req[i]  = ($urandom_range(0, 5) == 0);
                cur_word[i] = $urandom;
            end
            cur_ready = ($urandom_range(0, 4) != 0);
            cur_done  = ($urandom_range(0, 5) == 0);
            cur_clr   = ($urandom_range(0, 19) == 0);
            drive_inputs();

            if (cyc < 3 || (cyc > 10 && $urandom_range(0, 199) == 0)) begin
                if (cyc >= 3) $display("[%0t] reset pulse", $time);
                reset = 1'b1;
                model_reset(0);
                model_reset(1);
            end else begin
                reset = 1'b0;
                model_step(0);
                model_step(1);
            end
        end
        @(negedge proc_clk);
        compare_all();

        // Guard against a run where traffic never reached the processor.
        check("fix.any_issue", 32'(m_issues[0] > 20), 32'd1);
        check("rr.any_issue",  32'(m_issues[1] > 20), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
